// File: rtl/ascii_hex_parser_pkg.sv
// Shared ASCII character constants and parser state encoding.
package ascii_hex_parser_pkg;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UF    = 8'h46;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF    = 8'h66;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    // Decoder result: hex flag plus nibble value.
    typedef struct packed {
        logic       is_hex;
        logic [3:0] nib;
    } hex_dec_t;

endpackage

// File: rtl/ascii_hex_parser_if.sv
// Character-in / value-out bus of the ASCII hex parser.
interface ascii_hex_parser_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       char_in;
    logic             char_valid;
    logic             char_ready;
    logic [WIDTH-1:0] value_out;
    logic             value_valid;
    logic             value_ready;
    logic [WIDTH-1:0] acc_out;
    logic [3:0]       digit_count;
    logic             err;

    // Parser side
    modport slave (
        input  char_in, char_valid, value_ready,
        output char_ready, value_out, value_valid, acc_out, digit_count, err
    );

    // Character source / value consumer side
    modport master (
        output char_in, char_valid, value_ready,
        input  char_ready, value_out, value_valid, acc_out, digit_count, err
    );
endinterface

// File: rtl/ascii_hex_parser_hex_char_decode.sv
// Combinational ASCII hex digit decoder (case-insensitive).
module hex_char_decode
    import ascii_hex_parser_pkg::*;
(
    input  logic [7:0] char_i,
    output hex_dec_t   dec_o
);

    // Digits map through the low nibble; letters A-F/a-f share low nibble 1..6, offset by 9.
    always_comb begin
        dec_o = '0;
        if (char_i >= CH_0 && char_i <= CH_9) begin
            dec_o.is_hex = 1'b1;
            dec_o.nib    = char_i[3:0];
        end else if ((char_i >= CH_UA && char_i <= CH_UF) ||
                     (char_i >= CH_LA && char_i <= CH_LF)) begin
            dec_o.is_hex = 1'b1;
            dec_o.nib    = char_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// ASCII hex line parser: assembles hex digits MSD first, commits a line on CR
// and presents it through a valid/ready handshake.
module ascii_hex_parser
    import ascii_hex_parser_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         MAX_DIGITS = WIDTH / 4,
    parameter logic [7:0] CR_CODE    = CH_CR,
    parameter logic [7:0] BS_CODE    = CH_BS
) (
    input  logic               clk,
    input  logic               reset,
    ascii_hex_parser_if.slave  bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [WIDTH-1:0] val_q,   val_d;
    logic             vvld_q,  vvld_d;
    logic             err_q,   err_d;

    hex_dec_t dec;
    logic     accept;

    hex_char_decode u_dec (
        .char_i (bus.char_in),
        .dec_o  (dec)
    );

    // Ready depends on state only, so the source never sees a loop through char_valid.
    assign bus.char_ready  = (state_q != ST_HOLD);
    assign accept          = bus.char_valid && (state_q != ST_HOLD);

    assign bus.value_out   = val_q;
    assign bus.value_valid = vvld_q;
    assign bus.acc_out     = acc_q;
    assign bus.digit_count = cnt_q;
    assign bus.err         = err_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            vvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            vvld_q  <= vvld_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: line editing in IDLE/ACCUM, skip-to-CR in DISCARD, handshake in HOLD.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        vvld_d  = vvld_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    if (dec.is_hex) begin
                        if (cnt_q < MAX_CNT) begin
                            acc_d   = {acc_q[WIDTH-5:0], dec.nib};
                            cnt_d   = cnt_q + 4'd1;
                            state_d = ST_ACCUM;
                        end else begin
                            // Overflow: flag once, then swallow the rest of the line.
                            err_d   = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else if (bus.char_in == BS_CODE) begin
                        if (cnt_q != 4'd0) begin
                            acc_d = acc_q >> 4;
                            cnt_d = cnt_q - 4'd1;
                            if (cnt_q == 4'd1)
                                state_d = ST_IDLE;
                        end
                    end else if (bus.char_in == CR_CODE) begin
                        // Empty lines never commit.
                        if (cnt_q != 4'd0) begin
                            val_d   = acc_q;
                            vvld_d  = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end
                    end else if (bus.char_in != CH_SPACE) begin
                        err_d   = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end
            end

            ST_DISCARD: begin
                if (accept && bus.char_in == CR_CODE) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (vvld_q && bus.value_ready) begin
                    vvld_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Self-checking bench for ascii_hex_parser: directed scenarios plus a random
// character stream compared against a line-level reference model.
module tb_ascii_hex_parser;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] SP = 8'h20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   fails = 0;

    ascii_hex_parser_if #(.WIDTH(32)) bus ();

    ascii_hex_parser #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: the line is a list of digit values; flags say whether
    // the rest of the line is being thrown away or a result awaits pickup.
    int          m_digits[$];
    bit          m_discard;
    bit          m_hold;
    bit          m_vvalid;
    logic [31:0] m_vout;
    bit          m_err;

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    function automatic logic [31:0] m_acc();
        logic [31:0] v = 0;
        foreach (m_digits[i]) v = v * 16 + 32'(m_digits[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_discard = 0; m_hold = 0; m_vvalid = 0; m_vout = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [7:0] c, input bit cv, input bit vr);
        m_err = 0;
        if (m_hold) begin
            if (vr) begin m_vvalid = 0; m_hold = 0; end
        end else if (cv) begin
            if (m_discard) begin
                if (c == CR) begin m_digits.delete(); m_discard = 0; end
            end else if (is_hex(c)) begin
                if (m_digits.size() < 8) m_digits.push_back(hex_val(c));
                else begin m_err = 1; m_discard = 1; end
            end else if (c == BS) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (c == CR) begin
                if (m_digits.size() > 0) begin
                    m_vout = m_acc(); m_vvalid = 1; m_hold = 1; m_digits.delete();
                end
            end else if (c != SP) begin
                m_err = 1; m_discard = 1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, settle 1 time unit.
    task automatic tick(input logic [7:0] c, input bit cv, input bit vr);
        bus.char_in     = c;
        bus.char_valid  = cv;
        bus.value_ready = vr;
        @(posedge clk);
        model_step(c, cv, vr);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) tick(s[i], 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.char_in = 8'h00; bus.char_valid = 1'b0; bus.value_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.acc_out !== 32'h0) begin fails++; $display("FAIL reset_acc got=%h exp=0", bus.acc_out); end
        total++; if (bus.value_out !== 32'h0) begin fails++; $display("FAIL reset_vout got=%h exp=0", bus.value_out); end
        total++; if (bus.value_valid !== 1'b0) begin fails++; $display("FAIL reset_vvalid got=%b exp=0", bus.value_valid); end
        total++; if (bus.digit_count !== 4'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", bus.digit_count); end
        total++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        total++; if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.char_ready); end
    endtask

    task automatic test_basic();
        send_str("1A2b");
        total++; if (bus.acc_out !== 32'h1A2B) begin fails++; $display("FAIL basic_acc got=%h exp=00001a2b", bus.acc_out); end
        total++; if (bus.digit_count !== 4'd4) begin fails++; $display("FAIL basic_cnt got=%0d exp=4", bus.digit_count); end
        total++; if (bus.value_valid !== 1'b0) begin fails++; $display("FAIL basic_pre_vvalid got=%b exp=0", bus.value_valid); end
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.value_valid !== 1'b1) begin fails++; $display("FAIL basic_vvalid got=%b exp=1", bus.value_valid); end
        total++; if (bus.value_out !== 32'h00001A2B) begin fails++; $display("FAIL basic_vout got=%h exp=00001a2b", bus.value_out); end
        total++; if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL basic_hold_ready got=%b exp=0", bus.char_ready); end
        tick(8'h00, 1'b0, 1'b1);
        total++; if (bus.value_valid !== 1'b0 || bus.char_ready !== 1'b1) begin
            fails++; $display("FAIL basic_ack vvalid=%b ready=%b exp 0/1", bus.value_valid, bus.char_ready); end
    endtask

    task automatic test_overflow();
        send_str("DEADBEEF");
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.value_out !== 32'hDEADBEEF || bus.value_valid !== 1'b1) begin
            fails++; $display("FAIL full_vout got=%h/%b exp=deadbeef/1", bus.value_out, bus.value_valid); end
        tick(8'h00, 1'b0, 1'b1);
        send_str("12345678");
        tick("9", 1'b1, 1'b1);
        total++; if (bus.err !== 1'b1) begin fails++; $display("FAIL ovf_err got=%b exp=1", bus.err); end
        tick("Q", 1'b1, 1'b1);
        total++; if (bus.err !== 1'b0) begin fails++; $display("FAIL discard_no_err got=%b exp=0", bus.err); end
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.value_valid !== 1'b0 || bus.digit_count !== 4'd0 || bus.acc_out !== 32'h0) begin
            fails++; $display("FAIL discard_cr vvalid=%b cnt=%0d acc=%h exp 0/0/0", bus.value_valid, bus.digit_count, bus.acc_out); end
        total++; if (bus.value_out !== 32'hDEADBEEF) begin fails++; $display("FAIL discard_vout_kept got=%h exp=deadbeef", bus.value_out); end
    endtask

    task automatic test_backspace();
        tick(BS, 1'b1, 1'b1);
        total++; if (bus.err !== 1'b0 || bus.digit_count !== 4'd0) begin
            fails++; $display("FAIL bs_empty err=%b cnt=%0d exp 0/0", bus.err, bus.digit_count); end
        send_str("12");
        tick(BS, 1'b1, 1'b1);
        total++; if (bus.acc_out !== 32'h1 || bus.digit_count !== 4'd1) begin
            fails++; $display("FAIL bs_acc acc=%h cnt=%0d exp 1/1", bus.acc_out, bus.digit_count); end
        send_str("3");
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.value_out !== 32'h13) begin fails++; $display("FAIL bs_vout got=%h exp=00000013", bus.value_out); end
        tick(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_bad_char();
        send_str("7");
        tick("G", 1'b1, 1'b1);
        total++; if (bus.err !== 1'b1) begin fails++; $display("FAIL bad_err got=%b exp=1", bus.err); end
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.err !== 1'b0 || bus.value_valid !== 1'b0) begin
            fails++; $display("FAIL bad_nocommit err=%b vvalid=%b exp 0/0", bus.err, bus.value_valid); end
        send_str("5");
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.value_out !== 32'h5 || bus.value_valid !== 1'b1) begin
            fails++; $display("FAIL bad_recover got=%h/%b exp=00000005/1", bus.value_out, bus.value_valid); end
        tick(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_hold();
        send_str("42");
        tick(CR, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick("7", 1'b1, 1'b0);
            total++; if (bus.char_ready !== 1'b0 || bus.value_out !== 32'h42 || bus.value_valid !== 1'b1) begin
                fails++; $display("FAIL hold_stall%0d ready=%b vout=%h vvalid=%b exp 0/42/1", i, bus.char_ready, bus.value_out, bus.value_valid); end
        end
        // The '7' stays offered through the ack cycle; it is accepted once ready returns.
        tick("7", 1'b1, 1'b1);
        total++; if (bus.char_ready !== 1'b1 || bus.digit_count !== 4'd0) begin
            fails++; $display("FAIL hold_ack ready=%b cnt=%0d exp 1/0", bus.char_ready, bus.digit_count); end
        tick("7", 1'b1, 1'b1);
        tick(CR, 1'b1, 1'b1);
        total++; if (bus.value_out !== 32'h7) begin fails++; $display("FAIL hold_next got=%h exp=00000007", bus.value_out); end
        tick(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_str("ABC");
        reset = 1'b1;
        model_reset();
        #1;
        total++; if (bus.acc_out !== 32'h0 || bus.digit_count !== 4'd0 || bus.value_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid acc=%h cnt=%0d vvalid=%b exp 0/0/0", bus.acc_out, bus.digit_count, bus.value_valid); end
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] c;
        bit cv, vr;
        int r;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(99);
            if (r < 55) begin
                r = $urandom_range(21);
                c = (r < 10) ? 8'(48 + r) : (r < 16) ? 8'(55 + r) : 8'(87 + r - 6);
            end else if (r < 68) c = CR;
            else if (r < 80) c = BS;
            else if (r < 87) c = SP;
            else begin
                r = $urandom_range(3);
                c = (r == 0) ? "G" : (r == 1) ? "z" : (r == 2) ? "!" : 8'h7F;
            end
            cv = ($urandom_range(9) < 8);
            vr = ($urandom_range(9) < 6);
            tick(c, cv, vr);
            total++; if (bus.acc_out !== m_acc() || bus.digit_count !== 4'(m_digits.size())) begin
                fails++; $display("FAIL rand_acc n=%0d acc=%h cnt=%0d exp %h/%0d", n, bus.acc_out, bus.digit_count, m_acc(), m_digits.size()); end
            total++; if (bus.value_valid !== m_vvalid || bus.value_out !== m_vout) begin
                fails++; $display("FAIL rand_value n=%0d vvalid=%b vout=%h exp %b/%h", n, bus.value_valid, bus.value_out, m_vvalid, m_vout); end
            total++; if (bus.err !== m_err || bus.char_ready !== !m_hold) begin
                fails++; $display("FAIL rand_flags n=%0d err=%b ready=%b exp %b/%b", n, bus.err, bus.char_ready, m_err, !m_hold); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backspace();
        test_bad_char();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
